// File: rtl/wrr_apb_arbiter.sv
// ---------------------------------------------------------------------------
// wrr_apb_arbiter
//
// Weighted round-robin arbiter for up to 32 requesters, configured over APB.
// A granted client keeps the grant for up to its programmed weight in
// consecutive cycles, then the grant rotates to the next eligible client.
//
// Ports
//   Pclk_i, PResetn_i        clock, asynchronous active-low reset
//   PSel_i, PEnable_i,       APB slave (zero wait states, combinational read)
//   PWrite_i, PAddr_i,
//   PWData_i, PRData_o,
//   PReady_o, PSlvErr_o
//   req_i     [NUM_REQ]      level requests, held until served
//   gnt_o     [NUM_REQ]      registered one-hot grant
//   gnt_idx_o [5]            index of the granted client, 0 when idle
//
// Register map
//   0x00 CTRL    RW  [0] enable, [1] CLR (write-1 clears GNT_CNT, reads 0)
//   0x04 MASK    RW  [NUM_REQ-1:0] request mask, reset all ones
//   0x08 STATUS  RO  [4:0] index, [8] grant valid, [21:16] eligible count
//   0x0C GNT_CNT RO  number of grant loads, wraps
//   0x10+4k WEIGHT RW nibble j = weight of client 8k+j, reset 1
// ---------------------------------------------------------------------------
module wrr_apb_arbiter #(
    parameter int NUM_REQ  = 16,
    parameter int WEIGHT_W = 4
) (
    input  logic               Pclk_i,
    input  logic               PResetn_i,
    input  logic               PSel_i,
    input  logic               PEnable_i,
    input  logic               PWrite_i,
    input  logic [7:0]         PAddr_i,
    input  logic [31:0]        PWData_i,
    output logic [31:0]        PRData_o,
    output logic               PReady_o,
    output logic               PSlvErr_o,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [4:0]         gnt_idx_o
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic                        r_enable;
    logic [NUM_REQ-1:0]          r_mask;
    logic [NUM_REQ*WEIGHT_W-1:0] r_weight;
    logic [31:0]                 r_gnt_cnt;

    state_t                      r_state;
    logic [4:0]                  r_cur;
    logic [4:0]                  r_ptr;
    logic [WEIGHT_W-1:0]         r_credit;
    logic [NUM_REQ-1:0]          r_gnt;
    logic [4:0]                  r_gnt_idx;
    logic                        r_gnt_vld;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------
    function automatic logic [4:0] f_inc(input logic [4:0] idx);
        return (idx >= LAST_IDX) ? 5'd0 : idx + 5'd1;
    endfunction

    // First set bit of elig scanning upward from start, wrapping at NUM_REQ.
    function automatic logic [4:0] f_scan(input logic [31:0] elig, input logic [4:0] start);
        logic [4:0] win;
        logic       hit;
        logic [5:0] j;
        win = '0;
        hit = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = 6'(start) + 6'(k);
            if (j >= 6'(NUM_REQ)) begin
                j = j - 6'(NUM_REQ);
            end
            if (!hit && elig[j[4:0]]) begin
                hit = 1'b1;
                win = j[4:0];
            end
        end
        return win;
    endfunction

    function automatic logic [5:0] f_popcnt(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int k = 0; k < 32; k++) begin
            c = c + 6'(v[k]);
        end
        return c;
    endfunction

    // -----------------------------------------------------------------------
    // Eligibility and weights padded to the full 32-client space so that
    // 5-bit indices can address them directly.
    // -----------------------------------------------------------------------
    logic [31:0]  w_elig32;
    logic [127:0] w_weight_pad;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_pad
            if (gi < NUM_REQ) begin : g_real
                assign w_elig32[gi]            = req_i[gi] & r_mask[gi];
                assign w_weight_pad[gi*4 +: 4] = r_weight[gi*WEIGHT_W +: WEIGHT_W];
            end else begin : g_none
                assign w_elig32[gi]            = 1'b0;
                assign w_weight_pad[gi*4 +: 4] = 4'd0;
            end
        end
    endgenerate

    logic       w_any_elig;
    logic       w_cur_elig;
    logic [4:0] w_win_ptr;
    logic [4:0] w_win_cur;
    logic [5:0] w_elig_cnt;

    assign w_any_elig = |w_elig32;
    assign w_cur_elig = w_elig32[r_cur];
    assign w_win_ptr  = f_scan(w_elig32, r_ptr);
    assign w_win_cur  = f_scan(w_elig32, f_inc(r_cur));
    assign w_elig_cnt = f_popcnt(w_elig32);

    // -----------------------------------------------------------------------
    // APB decode
    // -----------------------------------------------------------------------
    logic w_access;
    logic w_wr;
    logic w_sel_ctrl;
    logic w_sel_mask;
    logic w_sel_status;
    logic w_sel_cnt;
    logic w_sel_wt;
    logic w_addr_ok;
    logic w_clr;

    assign w_access     = PSel_i & PEnable_i;
    assign w_wr         = w_access & PWrite_i;
    assign w_sel_ctrl   = (PAddr_i == 8'h00);
    assign w_sel_mask   = (PAddr_i == 8'h04);
    assign w_sel_status = (PAddr_i == 8'h08);
    assign w_sel_cnt    = (PAddr_i == 8'h0C);
    // The weight window always spans 4 words (32 clients); words past the
    // implemented clients decode as valid and read 0.
    assign w_sel_wt     = (PAddr_i[7:4] == 4'h1) && (PAddr_i[1:0] == 2'b00);
    assign w_addr_ok    = w_sel_ctrl | w_sel_mask | w_sel_status | w_sel_cnt | w_sel_wt;
    assign w_clr        = w_wr & w_sel_ctrl & PWData_i[1];

    logic [31:0] w_rdata;

    always_comb begin
        w_rdata = 32'd0;
        if (w_sel_ctrl) begin
            w_rdata = {31'd0, r_enable};
        end else if (w_sel_mask) begin
            w_rdata = 32'(r_mask);
        end else if (w_sel_status) begin
            w_rdata = {10'd0, w_elig_cnt, 7'd0, r_gnt_vld, 3'd0, r_gnt_idx};
        end else if (w_sel_cnt) begin
            w_rdata = r_gnt_cnt;
        end else if (w_sel_wt) begin
            w_rdata = w_weight_pad[{PAddr_i[3:2], 5'd0} +: 32];
        end
    end

    assign PRData_o  = (PSel_i & ~PWrite_i) ? w_rdata : 32'd0;
    assign PReady_o  = 1'b1;
    assign PSlvErr_o = w_access & (~w_addr_ok | (PWrite_i & (w_sel_status | w_sel_cnt)));

    // -----------------------------------------------------------------------
    // Arbitration FSM: next-state logic
    // -----------------------------------------------------------------------
    state_t              w_state_next;
    logic [4:0]          w_cur_next;
    logic [4:0]          w_ptr_next;
    logic [WEIGHT_W-1:0] w_credit_next;
    logic                w_load;
    logic [4:0]          w_win;
    logic [3:0]          w_win_wt;
    logic [NUM_REQ-1:0]  w_gnt_next;

    assign w_win_wt = w_weight_pad[{w_win, 2'b00} +: 4];

    always_comb begin
        w_state_next  = r_state;
        w_cur_next    = r_cur;
        w_ptr_next    = r_ptr;
        w_credit_next = r_credit;
        w_load        = 1'b0;
        w_win         = w_win_ptr;

        if (!r_enable) begin
            w_state_next  = S_IDLE;
            w_credit_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_elig) begin
                        w_load = 1'b1;
                        w_win  = w_win_ptr;
                    end
                end
                S_GRANT: begin
                    if (w_cur_elig && (r_credit > WEIGHT_W'(1))) begin
                        w_credit_next = r_credit - WEIGHT_W'(1);
                    end else if (w_any_elig) begin
                        // Scan starts after cur, so cur re-wins only when
                        // it is the sole eligible client.
                        w_load = 1'b1;
                        w_win  = w_win_cur;
                    end else begin
                        w_state_next  = S_IDLE;
                        w_credit_next = '0;
                    end
                end
                default: begin
                    w_state_next  = S_IDLE;
                    w_credit_next = '0;
                end
            endcase
        end

        if (w_load) begin
            w_state_next  = S_GRANT;
            w_cur_next    = w_win;
            w_ptr_next    = f_inc(w_win);
            // Weight 0 behaves as 1.
            w_credit_next = (w_win_wt == 4'd0) ? WEIGHT_W'(1) : WEIGHT_W'(w_win_wt);
        end
    end

    assign w_gnt_next = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_cur_next;

    // -----------------------------------------------------------------------
    // Arbitration FSM: state register and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge Pclk_i or negedge PResetn_i) begin
        if (!PResetn_i) begin
            r_state   <= S_IDLE;
            r_cur     <= '0;
            r_ptr     <= '0;
            r_credit  <= '0;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_gnt_vld <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cur    <= w_cur_next;
            r_ptr    <= w_ptr_next;
            r_credit <= w_credit_next;
            if (w_state_next == S_GRANT) begin
                r_gnt     <= w_gnt_next;
                r_gnt_idx <= w_cur_next;
                r_gnt_vld <= 1'b1;
            end else begin
                r_gnt     <= '0;
                r_gnt_idx <= '0;
                r_gnt_vld <= 1'b0;
            end
        end
    end

    assign gnt_o     = r_gnt;
    assign gnt_idx_o = r_gnt_idx;

    // -----------------------------------------------------------------------
    // Configuration registers and grant counter
    // -----------------------------------------------------------------------
    always_ff @(posedge Pclk_i or negedge PResetn_i) begin
        if (!PResetn_i) begin
            r_enable  <= 1'b0;
            r_mask    <= '1;
            r_weight  <= {NUM_REQ{WEIGHT_W'(1)}};
            r_gnt_cnt <= '0;
        end else begin
            if (w_wr && w_sel_ctrl) begin
                r_enable <= PWData_i[0];
            end
            if (w_wr && w_sel_mask) begin
                r_mask <= PWData_i[NUM_REQ-1:0];
            end
            if (w_wr && w_sel_wt) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if ((i / 8) == int'(PAddr_i[3:2])) begin
                        r_weight[i*WEIGHT_W +: WEIGHT_W] <= PWData_i[(i%8)*4 +: WEIGHT_W];
                    end
                end
            end
            // A clear in the same cycle as a grant load leaves the count at 0.
            if (w_clr) begin
                r_gnt_cnt <= '0;
            end else if (w_load) begin
                r_gnt_cnt <= r_gnt_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_wrr_apb_arbiter.sv
module tb_wrr_apb_arbiter;

    logic        Pclk_i = 1'b0;
    logic        PResetn_i = 1'b0;
    logic        PSel_i = 1'b0;
    logic        PEnable_i = 1'b0;
    logic        PWrite_i = 1'b0;
    logic [7:0]  PAddr_i = 8'd0;
    logic [31:0] PWData_i = 32'd0;
    logic [31:0] PRData_o;
    logic        PReady_o;
    logic        PSlvErr_o;
    logic [15:0] req_i = 16'd0;
    logic [15:0] gnt_o;
    logic [4:0]  gnt_idx_o;

    int checks = 0;
    int errors = 0;

    wrr_apb_arbiter #(.NUM_REQ(16), .WEIGHT_W(4)) dut (
        .Pclk_i    (Pclk_i),
        .PResetn_i (PResetn_i),
        .PSel_i    (PSel_i),
        .PEnable_i (PEnable_i),
        .PWrite_i  (PWrite_i),
        .PAddr_i   (PAddr_i),
        .PWData_i  (PWData_i),
        .PRData_o  (PRData_o),
        .PReady_o  (PReady_o),
        .PSlvErr_o (PSlvErr_o),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .gnt_idx_o (gnt_idx_o)
    );

    always #5 Pclk_i = ~Pclk_i;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- helpers
    task automatic do_reset();
        PResetn_i = 1'b0;
        PSel_i = 1'b0; PEnable_i = 1'b0; PWrite_i = 1'b0;
        PAddr_i = 8'd0; PWData_i = 32'd0; req_i = 16'd0;
        repeat (2) @(negedge Pclk_i);
        PResetn_i = 1'b1;
    endtask

    // Starts right after a negedge, returns on the negedge after the commit edge.
    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data, output logic err);
        PSel_i = 1'b1; PEnable_i = 1'b0; PWrite_i = 1'b1;
        PAddr_i = addr; PWData_i = data;
        @(negedge Pclk_i);
        PEnable_i = 1'b1;
        #1 err = PSlvErr_o;
        @(negedge Pclk_i);
        PSel_i = 1'b0; PEnable_i = 1'b0; PWrite_i = 1'b0;
        $display("apb wr addr=%h data=%h slverr=%0b", addr, data, err);
    endtask

    // Combinational read, consumes 1 ns and no clock edge.
    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data, output logic err);
        PSel_i = 1'b1; PEnable_i = 1'b1; PWrite_i = 1'b0; PAddr_i = addr;
        #1 data = PRData_o; err = PSlvErr_o;
        PSel_i = 1'b0; PEnable_i = 1'b0; PAddr_i = 8'd0;
        $display("apb rd addr=%h data=%h slverr=%0b", addr, data, err);
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        logic [31:0] rd; logic e;
        do_reset();
        #1;
        checks++; if (gnt_o !== 16'd0) begin errors++; $display("FAIL reset_gnt got=%h exp=0000", gnt_o); end
        checks++; if (gnt_idx_o !== 5'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", gnt_idx_o); end
        checks++; if (PReady_o !== 1'b1) begin errors++; $display("FAIL reset_pready got=%b exp=1", PReady_o); end
        checks++; if (PSlvErr_o !== 1'b0) begin errors++; $display("FAIL reset_pslverr got=%b exp=0", PSlvErr_o); end
        checks++; if (PRData_o !== 32'd0) begin errors++; $display("FAIL reset_prdata got=%h exp=0", PRData_o); end
        apb_read(8'h04, rd, e);
        checks++; if (rd !== 32'h0000FFFF) begin errors++; $display("FAIL reset_mask got=%h exp=0000ffff", rd); end
        apb_read(8'h10, rd, e);
        checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL reset_weight0 got=%h exp=11111111", rd); end
        apb_read(8'h08, rd, e);
        checks++; if (rd !== 32'h00000000) begin errors++; $display("FAIL reset_status got=%h exp=0", rd); end
        @(negedge Pclk_i);
        apb_read(8'h0C, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_gntcnt got=%h exp=0", rd); end
        apb_read(8'h00, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", rd); end
    endtask

    task automatic test_rotation();
        logic [31:0] rd; logic e;
        logic [15:0] exp_g;
        do_reset();
        req_i = 16'h000F;
        apb_write(8'h00, 32'h1, e);
        for (int i = 0; i < 8; i++) begin
            @(negedge Pclk_i);
            exp_g = 16'd1 << (i % 4);
            checks++; if (gnt_o !== exp_g) begin errors++; $display("FAIL rotation_gnt cyc=%0d got=%h exp=%h", i, gnt_o, exp_g); end
            checks++; if (gnt_idx_o !== 5'(i % 4)) begin errors++; $display("FAIL rotation_idx cyc=%0d got=%0d exp=%0d", i, gnt_idx_o, i % 4); end
            apb_read(8'h0C, rd, e);
            checks++; if (rd !== 32'(i + 1)) begin errors++; $display("FAIL rotation_cnt cyc=%0d got=%0d exp=%0d", i, rd, i + 1); end
        end
    endtask

    task automatic test_weights();
        logic [31:0] rd; logic e;
        int pat[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        do_reset();
        apb_write(8'h10, 32'h11111113, e);
        req_i = 16'h0003;
        apb_write(8'h00, 32'h1, e);
        for (int i = 0; i < 8; i++) begin
            @(negedge Pclk_i);
            checks++; if (gnt_idx_o !== 5'(pat[i])) begin errors++; $display("FAIL weights_idx cyc=%0d got=%0d exp=%0d", i, gnt_idx_o, pat[i]); end
            checks++; if (gnt_o !== (16'd1 << pat[i])) begin errors++; $display("FAIL weights_gnt cyc=%0d got=%h exp=%h", i, gnt_o, 16'd1 << pat[i]); end
        end
        apb_read(8'h0C, rd, e);
        checks++; if (rd !== 32'd4) begin errors++; $display("FAIL weights_cnt got=%0d exp=4", rd); end
    endtask

    task automatic test_weight_zero();
        logic e;
        int pat[4] = '{0, 1, 0, 1};
        do_reset();
        apb_write(8'h10, 32'h11111110, e);
        req_i = 16'h0003;
        apb_write(8'h00, 32'h1, e);
        for (int i = 0; i < 4; i++) begin
            @(negedge Pclk_i);
            checks++; if (gnt_idx_o !== 5'(pat[i])) begin errors++; $display("FAIL weight_zero_idx cyc=%0d got=%0d exp=%0d", i, gnt_idx_o, pat[i]); end
        end
    endtask

    task automatic test_req_drop();
        logic [31:0] rd; logic e;
        do_reset();
        apb_write(8'h10, 32'h11111411, e);
        req_i = 16'h000C;
        apb_write(8'h00, 32'h1, e);
        @(negedge Pclk_i);
        checks++; if (gnt_o !== 16'h0004) begin errors++; $display("FAIL drop_first got=%h exp=0004", gnt_o); end
        @(negedge Pclk_i);
        checks++; if (gnt_o !== 16'h0004) begin errors++; $display("FAIL drop_hold got=%h exp=0004", gnt_o); end
        apb_read(8'h08, rd, e);
        checks++; if (rd !== 32'h00020102) begin errors++; $display("FAIL drop_status_before got=%h exp=00020102", rd); end
        req_i = 16'h0008;
        #1;
        checks++; if (gnt_o !== 16'h0004) begin errors++; $display("FAIL drop_same_cycle got=%h exp=0004", gnt_o); end
        @(negedge Pclk_i);
        checks++; if (gnt_o !== 16'h0008) begin errors++; $display("FAIL drop_moved got=%h exp=0008", gnt_o); end
        checks++; if (gnt_idx_o !== 5'd3) begin errors++; $display("FAIL drop_idx got=%0d exp=3", gnt_idx_o); end
        apb_read(8'h08, rd, e);
        checks++; if (rd !== 32'h00010103) begin errors++; $display("FAIL drop_status_after got=%h exp=00010103", rd); end
    endtask

    task automatic test_mask();
        logic [31:0] rd; logic e;
        do_reset();
        apb_write(8'h04, 32'h0000FFFE, e);
        req_i = 16'h0001;
        apb_write(8'h00, 32'h1, e);
        for (int i = 0; i < 3; i++) begin
            @(negedge Pclk_i);
            checks++; if (gnt_o !== 16'd0) begin errors++; $display("FAIL mask_blocked cyc=%0d got=%h exp=0000", i, gnt_o); end
        end
        apb_read(8'h08, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mask_status got=%h exp=0", rd); end
        apb_write(8'h04, 32'h0000FFFF, e);
        checks++; if (gnt_o !== 16'd0) begin errors++; $display("FAIL mask_commit_edge got=%h exp=0000", gnt_o); end
        @(negedge Pclk_i);
        checks++; if (gnt_o !== 16'h0001) begin errors++; $display("FAIL mask_released got=%h exp=0001", gnt_o); end
        apb_read(8'h08, rd, e);
        checks++; if (rd !== 32'h00010100) begin errors++; $display("FAIL mask_status_grant got=%h exp=00010100", rd); end
    endtask

    task automatic test_bad_addr();
        logic [31:0] rd; logic e;
        do_reset();
        apb_read(8'h40, rd, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL badaddr_err got=%b exp=1", e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL badaddr_data got=%h exp=0", rd); end
        apb_read(8'h18, rd, e);
        checks++; if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL unimpl_weight got=%h/%b exp=0/0", rd, e); end
        apb_read(8'h14, rd, e);
        checks++; if (rd !== 32'h11111111 || e !== 1'b0) begin errors++; $display("FAIL weight1 got=%h/%b exp=11111111/0", rd, e); end
    endtask

    task automatic test_ro_write();
        logic [31:0] rd; logic e;
        do_reset();
        apb_write(8'h08, 32'hFFFFFFFF, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL ro_status_err got=%b exp=1", e); end
        apb_write(8'h0C, 32'hFFFFFFFF, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL ro_cnt_err got=%b exp=1", e); end
        apb_read(8'h0C, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ro_cnt_unchanged got=%h exp=0", rd); end
        apb_read(8'h00, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ro_ctrl_unchanged got=%h exp=0", rd); end
        apb_write(8'h04, 32'h0000FFFF, e);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL rw_mask_err got=%b exp=0", e); end
    endtask

    task automatic test_enable_resume();
        logic [31:0] rd; logic e;
        do_reset();
        req_i = 16'h000F;
        apb_write(8'h00, 32'h1, e);
        @(negedge Pclk_i);
        checks++; if (gnt_o !== 16'h0001) begin errors++; $display("FAIL en_first got=%h exp=0001", gnt_o); end
        apb_write(8'h00, 32'h0, e);
        checks++; if (gnt_o !== 16'h0004) begin errors++; $display("FAIL en_commit_edge got=%h exp=0004", gnt_o); end
        @(negedge Pclk_i);
        checks++; if (gnt_o !== 16'h0000 || gnt_idx_o !== 5'd0) begin errors++; $display("FAIL en_stopped got=%h/%0d exp=0000/0", gnt_o, gnt_idx_o); end
        req_i = 16'h0009;
        @(negedge Pclk_i);
        checks++; if (gnt_o !== 16'h0000) begin errors++; $display("FAIL en_idle got=%h exp=0000", gnt_o); end
        apb_write(8'h00, 32'h1, e);
        checks++; if (gnt_o !== 16'h0000) begin errors++; $display("FAIL en_restart_edge got=%h exp=0000", gnt_o); end
        @(negedge Pclk_i);
        checks++; if (gnt_idx_o !== 5'd3) begin errors++; $display("FAIL en_resume_ptr got=%0d exp=3", gnt_idx_o); end
        @(negedge Pclk_i);
        checks++; if (gnt_idx_o !== 5'd0) begin errors++; $display("FAIL en_wrap got=%0d exp=0", gnt_idx_o); end
        apb_write(8'h00, 32'h3, e);
        apb_read(8'h0C, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL clr_wins got=%0d exp=0", rd); end
        apb_read(8'h00, rd, e);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL clr_selfclear got=%h exp=1", rd); end
        @(negedge Pclk_i);
        apb_read(8'h0C, rd, e);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL clr_recount got=%0d exp=1", rd); end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd; logic e;
        do_reset();
        req_i = 16'h0001;
        apb_write(8'h00, 32'h1, e);
        @(negedge Pclk_i);
        checks++; if (gnt_o !== 16'h0001) begin errors++; $display("FAIL arst_pre got=%h exp=0001", gnt_o); end
        #2 PResetn_i = 1'b0;
        #1;
        checks++; if (gnt_o !== 16'h0000 || gnt_idx_o !== 5'd0) begin errors++; $display("FAIL arst_clear got=%h/%0d exp=0000/0", gnt_o, gnt_idx_o); end
        apb_read(8'h00, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL arst_ctrl got=%h exp=0", rd); end
        @(negedge Pclk_i);
        PResetn_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_weights();
        test_weight_zero();
        test_req_drop();
        test_mask();
        test_bad_addr();
        test_ro_write();
        test_enable_resume();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
